gp_acmp_sequencer: RTL
======================

Name: gp_acmp_sequencer

Overview:
- Synthesizable digital companion to the GreenPAK analog comparator cell.
- Power-up control:
  - Waits for power-on-reset done (GP_POR RST_DONE) and bandgap ready (GP_BANDGAP OK).
  - Drives the comparator PWREN.
  - Waits a settling interval.
- Qualifies the raw comparator output:
  - Synchronizes and deglitches it.
  - Produces a clean level plus edge pulses for downstream counters and FSMs.

Parameters:
- SETTLE_CYCLES, 16: CLK cycles between PWREN rising and VALID rising; legal range 1..65535.
- FILTER_CYCLES, 4: consecutive stable synchronized samples needed to change CMP; legal range 1..255.
- TIMEOUT_CYCLES, 1024: max CLK cycles to wait for bandgap OK before FAULT; legal range 1..65535.

Ports:
- CLK, input, 1: sole clock; all outputs registered on its rising edge.
- RST, input, 1: asynchronous, active-high reset.
- ENABLE, input, 1: synchronous request to power and run the comparator path.
- RST_DONE, input, 1: async from POR cell; 2-flop synchronized internally.
- BG_OK, input, 1: async from bandgap cell; 2-flop synchronized internally.
- ACMP_OUT, input, 1: async raw comparator output; 2-flop synchronized internally.
- PWREN, output, 1: comparator power enable.
- VALID, output, 1: high while in RUN; CMP is trustworthy.
- CMP, output, 1: filtered comparator level.
- RISE, output, 1: one-cycle pulse when CMP goes 0->1.
- FALL, output, 1: one-cycle pulse when CMP goes 1->0.
- FAULT, output, 1: sticky bandgap-timeout flag.

Behaviour:
- Reset (RST high, asynchronous):
  - All outputs 0.
  - State OFF.
  - Synchronizer flops, filter counter, settle counter and timeout counter all 0.
- States (one-hot or binary, registered): OFF, WAIT_POR, WAIT_BG, SETTLE, RUN, FLT.
- OFF:
  - Outputs PWREN=0, VALID=0, CMP=0.
  - ENABLE=1 -> WAIT_POR.
- WAIT_POR:
  - Sync RST_DONE=1 -> WAIT_BG; timeout counter cleared.
- WAIT_BG:
  - Timeout counter increments each cycle.
  - Sync BG_OK=1 -> SETTLE, PWREN=1 from the next cycle, settle counter cleared.
  - Counter reaches TIMEOUT_CYCLES-1 with BG_OK still low -> FLT.
  - If BG_OK rises on that same cycle, BG_OK wins.
- SETTLE:
  - PWREN=1; settle counter increments.
  - Counter == SETTLE_CYCLES-1 -> RUN.
  - VALID rises exactly SETTLE_CYCLES cycles after PWREN rises.
  - Filter is preloaded at RUN entry: CMP = current synced ACMP_OUT, counter 0, no edge pulse.
- RUN:
  - VALID=1, PWREN=1.
  - Filter, per cycle:
    - Synced input == CMP: counter := 0.
    - Otherwise counter += 1.
    - Counter reaches FILTER_CYCLES-1 while still differing: CMP toggles, counter := 0, RISE or FALL pulses that same cycle as the CMP change.
  - Net delay from a clean input step to the CMP change: 2 (sync) + FILTER_CYCLES cycles.
  - A glitch shorter than FILTER_CYCLES synced samples produces no CMP change.
- FLT:
  - FAULT=1, PWREN=0, VALID=0.
  - Exit only via ENABLE=0 -> OFF, which clears FAULT.
- ENABLE=0 in any state other than FLT:
  - Next state OFF.
  - PWREN, VALID, CMP go to 0 next cycle.
  - No FALL pulse is generated by this forced clear.
- Sync BG_OK dropping in SETTLE or RUN:
  - -> WAIT_BG (timeout restarted).
  - PWREN, VALID, CMP cleared next cycle; no edge pulse.
- Sync RST_DONE dropping in any state past WAIT_POR (brown-out): -> WAIT_POR with the same clearing.
- Priority when events coincide: RST > ENABLE=0 > RST_DONE drop > BG_OK drop > normal transition.
- RISE and FALL are never both high. Neither is ever high while VALID=0.
- Counter widths:
  - Settle and timeout counters: 16 bits, saturating, never wrap.
  - Filter counter: 8 bits.

Decomposition:
- Shared include file (gp_acmp_defs.vh):
  - State encoding localparams.
  - Counter width constants (16, 8).
  - Synchronizer depth constant (2).
- One sub-module: gp_acmp_filter.
  - Synchronizer, counter, level and edge outputs.
  - Inputs: CLK, RST, run, din.
  - Outputs: cmp, rise, fall.
  - Reused by the team's digital deglitch cells.

Test Plan:
1. Nominal bring-up (defaults):
   - Stimulus: RST released; ENABLE=1; RST_DONE=1 at cycle 5; BG_OK=1 at cycle 20.
   - Response: PWREN rises at cycle 23 (2 sync + 1); VALID rises 16 cycles later; CMP equals ACMP_OUT with no RISE at entry.
2. Deglitch:
   - Stimulus: in RUN with CMP=0, pulse ACMP_OUT high for 3 cycles.
   - Response: no CMP change, no RISE.
   - Stimulus: hold ACMP_OUT high for 10 cycles.
   - Response: CMP=1 and a single RISE exactly 6 cycles after the step.
3. Bandgap timeout:
   - Stimulus: BG_OK held 0.
   - Response: FAULT=1 after 1024 cycles in WAIT_BG; PWREN=0.
   - Stimulus: ENABLE=0.
   - Response: FAULT=0 next cycle, state OFF.
4. Brown-out mid-RUN:
   - Stimulus: with CMP=1, drop BG_OK.
   - Response: PWREN, VALID, CMP go to 0 after the sync delay; no FALL pulse.
   - Stimulus: restore BG_OK.
   - Response: full SETTLE repeats.
5. Async reset mid-SETTLE:
   - Stimulus: assert RST between clock edges.
   - Response: all outputs 0 immediately.
   - Stimulus: release RST.
   - Response: bring-up restarts from OFF.
6. Parameter corners:
   - Stimulus: FILTER_CYCLES=1, SETTLE_CYCLES=1; single-cycle synced ACMP_OUT change.
   - Response: CMP follows with 1-cycle filter delay; VALID one cycle after PWREN.

Source files
------------

// File: rtl/gp_acmp_sequencer_pkg.sv
// Shared types and constants for the GreenPAK comparator sequencer and its
// deglitch filter.
package gp_acmp_sequencer_pkg;

  localparam int CNT_W      = 16;
  localparam int FILT_W     = 8;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_WAIT_POR = 3'd1,
    ST_WAIT_BG  = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_RUN      = 3'd4,
    ST_FLT      = 3'd5
  } state_t;

  // Settle/timeout counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/gp_acmp_sequencer_filter.sv
// Synchronizer plus consecutive-sample deglitch filter; produces a clean level
// and one-cycle edge pulses while run is high, and holds everything low otherwise.
module gp_acmp_filter
  import gp_acmp_sequencer_pkg::*;
#(
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic din,
  output logic cmp,
  output logic rise,
  output logic fall
);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] sync_reg;
  logic [FILT_W-1:0]     cnt_reg;
  logic                  run_reg;
  logic                  cmp_reg;
  logic                  rise_reg;
  logic                  fall_reg;
  logic                  din_s;

  assign din_s = sync_reg[SYNC_DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      cnt_reg  <= '0;
      run_reg  <= 1'b0;
      cmp_reg  <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_DEPTH-2:0], din};
      run_reg  <= run;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (!run) begin
        cmp_reg <= 1'b0;
        cnt_reg <= '0;
      end else if (!run_reg) begin
        // First RUN cycle: adopt the current level silently, no edge pulse.
        cmp_reg <= din_s;
        cnt_reg <= '0;
      end else if (din_s == cmp_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == FILT_LAST) begin
        cmp_reg  <= din_s;
        cnt_reg  <= '0;
        rise_reg <= din_s;
        fall_reg <= ~din_s;
      end else begin
        cnt_reg <= cnt_reg + FILT_W'(1);
      end
    end
  end

  assign cmp  = cmp_reg;
  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/gp_acmp_sequencer.sv
// Power-up sequencer for the GreenPAK analog comparator: waits for POR and
// bandgap, powers the comparator, settles, then qualifies its output.
module gp_acmp_sequencer
  import gp_acmp_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int FILTER_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic rst_done,
  input  logic bg_ok,
  input  logic acmp_out,
  output logic pwren,
  output logic valid,
  output logic cmp,
  output logic rise,
  output logic fall,
  output logic fault
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_DEPTH-1:0] rd_sync_reg;
  logic [SYNC_DEPTH-1:0] bg_sync_reg;
  logic                  rd_s;
  logic                  bg_s;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] settle_cnt_reg, settle_cnt_next;
  logic [CNT_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             pwren_reg;
  logic             valid_reg;
  logic             fault_reg;
  logic             run;

  assign rd_s = rd_sync_reg[SYNC_DEPTH-1];
  assign bg_s = bg_sync_reg[SYNC_DEPTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_sync_reg    <= '0;
      bg_sync_reg    <= '0;
      state_reg      <= ST_OFF;
      settle_cnt_reg <= '0;
      tmo_cnt_reg    <= '0;
      pwren_reg      <= 1'b0;
      valid_reg      <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      rd_sync_reg    <= {rd_sync_reg[SYNC_DEPTH-2:0], rst_done};
      bg_sync_reg    <= {bg_sync_reg[SYNC_DEPTH-2:0], bg_ok};
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      pwren_reg      <= (state_next == ST_SETTLE) || (state_next == ST_RUN);
      valid_reg      <= (state_next == ST_RUN);
      fault_reg      <= (state_next == ST_FLT);
    end
  end

  // Check order inside each state encodes the brown-out priority.
  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = ST_OFF;
    end else begin
      case (state_reg)
        ST_OFF:      state_next = ST_WAIT_POR;
        ST_WAIT_POR: if (rd_s) state_next = ST_WAIT_BG;
        ST_WAIT_BG: begin
          if (!rd_s)                    state_next = ST_WAIT_POR;
          else if (bg_s)                state_next = ST_SETTLE;
          else if (tmo_cnt_reg == TMO_LAST) state_next = ST_FLT;
        end
        ST_SETTLE: begin
          if (!rd_s)                           state_next = ST_WAIT_POR;
          else if (!bg_s)                      state_next = ST_WAIT_BG;
          else if (settle_cnt_reg == SETTLE_LAST) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (!rd_s)       state_next = ST_WAIT_POR;
          else if (!bg_s)  state_next = ST_WAIT_BG;
        end
        ST_FLT:  state_next = ST_FLT;
        default: state_next = ST_OFF;
      endcase
    end
  end

  // Counters only run in their own state, so every entry starts from zero.
  always_comb begin
    tmo_cnt_next    = (state_reg == ST_WAIT_BG) ? sat_inc(tmo_cnt_reg) : '0;
    settle_cnt_next = (state_reg == ST_SETTLE) ? sat_inc(settle_cnt_reg) : '0;
  end

  assign run = (state_next == ST_RUN);

  gp_acmp_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filter (
    .clk (clk),
    .rst (rst),
    .run (run),
    .din (acmp_out),
    .cmp (cmp),
    .rise(rise),
    .fall(fall)
  );

  assign pwren = pwren_reg;
  assign valid = valid_reg;
  assign fault = fault_reg;

endmodule
